// File: rtl/result_ascii_encoder_pkg.sv
// Shared byte/ASCII definitions for the text-side blocks (input parser and
// result encoder), plus a digit-to-character helper.
package result_ascii_encoder_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Printable character for one BCD digit (0..9).
  function automatic logic [7:0] ascii_digit(input logic [3:0] digit);
    return ASCII_ZERO + 8'(digit);
  endfunction

endpackage : result_ascii_encoder_pkg

// File: rtl/result_ascii_encoder_bcd_double_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - load value and begin converting (ignored while busy)
//   value      - unsigned binary input, sampled when start is taken
//   busy       - conversion in progress
//   done_c     - high in the cycle whose clock edge performs the final shift
//   bcd        - DIGIT_COUNT packed BCD digits, digit 0 in the low nibble;
//                holds the result until the next start
module bcd_double_dabble #(
  parameter int unsigned VALUE_WIDTH = 64,
  parameter int unsigned DIGIT_COUNT = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [VALUE_WIDTH-1:0]     value,
  output logic                       busy,
  output logic                       done_c,
  output logic [4*DIGIT_COUNT-1:0]   bcd
);

  localparam int unsigned BCD_W = 4 * DIGIT_COUNT;
  localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);
  localparam int unsigned CAT_W = BCD_W + VALUE_WIDTH;

  logic [VALUE_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BCD_W-1:0]       adj_c;
  logic [CAT_W-1:0]       shifted_c;

  // Add 3 to every digit >= 5; nibbles are independent, no carry between them.
  always_comb begin
    adj_c = bcd;
    for (int unsigned i = 0; i < DIGIT_COUNT; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // {bcd, shift} moves left as one register; the adjusted BCD MSB is always 0
  // when 10^DIGIT_COUNT exceeds the largest input, so nothing is lost.
  assign shifted_c = {adj_c, shift_q} << 1;

  assign done_c = busy && (cnt_q == CNT_W'(1));

  // Conversion registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      bcd     <= '0;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      cnt_q   <= CNT_W'(VALUE_WIDTH);
      shift_q <= value;
      bcd     <= '0;
    end else if (busy) begin
      busy    <= (cnt_q != CNT_W'(1));
      cnt_q   <= cnt_q - CNT_W'(1);
      shift_q <= shifted_c[VALUE_WIDTH-1:0];
      bcd     <= shifted_c[CAT_W-1:VALUE_WIDTH];
    end
  end

endmodule : bcd_double_dabble

// File: rtl/result_ascii_encoder.sv
// Turns a binary result into ASCII decimal text ending in a line feed, one
// byte per valid/ready handshake, for a byte-wide TAP encoder.
// Ports:
//   tck               - clock
//   test_logic_reset  - synchronous active-high reset
//   value_valid/value_data/value_ready - binary value input handshake
//   byte_valid/byte_data/byte_last/byte_ready - ASCII byte output handshake;
//                       byte_last marks the terminating line feed
module result_ascii_encoder #(
  parameter int unsigned VALUE_WIDTH = 64,
  parameter int unsigned DIGIT_COUNT = 20,
  parameter int unsigned BYTE_WIDTH  = result_ascii_encoder_pkg::BYTE_WIDTH
) (
  input  logic                   tck,
  input  logic                   test_logic_reset,
  input  logic                   value_valid,
  input  logic [VALUE_WIDTH-1:0] value_data,
  output logic                   value_ready,
  output logic                   byte_valid,
  output logic [BYTE_WIDTH-1:0]  byte_data,
  output logic                   byte_last,
  input  logic                   byte_ready
);

  import result_ascii_encoder_pkg::*;

  localparam int unsigned BCD_W = 4 * DIGIT_COUNT;
  localparam int unsigned PTR_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SCAN,
    ST_EMIT,
    ST_NEWLINE
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    scan_ptr_c;
  logic                byte_valid_d, byte_last_d;
  logic [BYTE_WIDTH-1:0] byte_data_d;

  logic                dd_start;
  logic                dd_busy;
  logic                dd_done_c;
  logic [BCD_W-1:0]    bcd;

  // Reset forces IDLE on the next edge, so advertise ready while it is held.
  assign value_ready = (state_q == ST_IDLE) || test_logic_reset;
  assign dd_start    = value_valid && (state_q == ST_IDLE);

  bcd_double_dabble #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .DIGIT_COUNT (DIGIT_COUNT)
  ) u_dabble (
    .clk    (tck),
    .rst    (test_logic_reset),
    .start  (dd_start),
    .value  (value_data),
    .busy   (dd_busy),
    .done_c (dd_done_c),
    .bcd    (bcd)
  );

  // Digit select by index.
  function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] digits,
                                          input logic [PTR_W-1:0] idx);
    logic [3:0] d;
    d = '0;
    for (int unsigned i = 0; i < DIGIT_COUNT; i++) begin
      if (PTR_W'(i) == idx) begin
        d = digits[4*i +: 4];
      end
    end
    return d;
  endfunction

  // Most significant nonzero digit; stays 0 for an all-zero result so "0" is sent.
  always_comb begin
    scan_ptr_c = '0;
    for (int unsigned i = 0; i < DIGIT_COUNT; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        scan_ptr_c = PTR_W'(i);
      end
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_last  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_valid <= byte_valid_d;
      byte_data  <= byte_data_d;
      byte_last  <= byte_last_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (value_valid) state_d = ST_CONVERT;
      ST_CONVERT: if (dd_done_c || !dd_busy) state_d = ST_SCAN;
      ST_SCAN:    state_d = ST_EMIT;
      ST_EMIT:    if (byte_ready && (ptr_q == '0)) state_d = ST_NEWLINE;
      ST_NEWLINE: if (byte_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Next pointer and output byte; outputs hold while stalled.
  always_comb begin
    ptr_d        = ptr_q;
    byte_valid_d = byte_valid;
    byte_data_d  = byte_data;
    byte_last_d  = byte_last;
    unique case (state_q)
      ST_SCAN: begin
        ptr_d        = scan_ptr_c;
        byte_valid_d = 1'b1;
        byte_data_d  = BYTE_WIDTH'(ascii_digit(digit_at(bcd, scan_ptr_c)));
        byte_last_d  = 1'b0;
      end
      ST_EMIT: begin
        if (byte_ready) begin
          if (ptr_q == '0) begin
            byte_valid_d = 1'b1;
            byte_data_d  = BYTE_WIDTH'(ASCII_LF);
            byte_last_d  = 1'b1;
          end else begin
            ptr_d        = ptr_q - PTR_W'(1);
            byte_valid_d = 1'b1;
            byte_data_d  = BYTE_WIDTH'(ascii_digit(digit_at(bcd, ptr_q - PTR_W'(1))));
            byte_last_d  = 1'b0;
          end
        end
      end
      ST_NEWLINE: begin
        if (byte_ready) begin
          byte_valid_d = 1'b0;
          byte_data_d  = '0;
          byte_last_d  = 1'b0;
        end
      end
      default: begin
        byte_valid_d = 1'b0;
        byte_data_d  = '0;
        byte_last_d  = 1'b0;
      end
    endcase
  end

endmodule : result_ascii_encoder

// File: tb/tb_result_ascii_encoder.sv
// Self-checking bench for result_ascii_encoder: directed corner values plus
// random values with random byte_ready duty, checked every cycle against a
// decimal-string reference model.
module tb_result_ascii_encoder;

  localparam int unsigned VW = 64;
  localparam int unsigned DC = 20;
  localparam int unsigned BW = 8;
  localparam int unsigned LATENCY = VW + 1;

  logic          tck = 1'b0;
  logic          test_logic_reset;
  logic          value_valid;
  logic [VW-1:0] value_data;
  logic          value_ready;
  logic          byte_valid;
  logic [BW-1:0] byte_data;
  logic          byte_last;
  logic          byte_ready;

  always #5 tck = ~tck;

  result_ascii_encoder #(
    .VALUE_WIDTH (VW),
    .DIGIT_COUNT (DC),
    .BYTE_WIDTH  (BW)
  ) dut (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .value_valid      (value_valid),
    .value_data       (value_data),
    .value_ready      (value_ready),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_last        (byte_last),
    .byte_ready       (byte_ready)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [7:0]      exp_q[$];
  bit              model_busy  = 1'b0;
  bit              post_reset  = 1'b0;
  longint unsigned cyc         = 0;
  longint unsigned accept_cyc  = 0;
  int              accept_count = 0;
  int              pop_count    = 0;
  int              duty         = 100;

  // Expected text: decimal digits without leading zeros, then LF.
  function automatic void push_expected(input logic [63:0] v);
    logic [7:0]  digits[$];
    logic [63:0] x;
    x = v;
    if (x == 64'd0) digits.push_back(8'h30);
    while (x != 64'd0) begin
      digits.push_front(8'h30 + 8'(x % 64'd10));
      x = x / 64'd10;
    end
    foreach (digits[i]) exp_q.push_back(digits[i]);
    exp_q.push_back(8'h0A);
  endfunction

  always @(posedge tck) cyc <= cyc + 1;

  // Per-cycle monitor: compare outputs, then advance the model for the coming edge.
  always @(negedge tck) begin
    bit exp_valid;
    bit can_accept;
    exp_valid  = model_busy && ((cyc - accept_cyc) >= LATENCY);
    can_accept = !model_busy;

    check("value_ready", 64'(value_ready), test_logic_reset ? 64'd1 : 64'(can_accept));
    check("byte_valid", 64'(byte_valid), 64'(exp_valid));
    if (post_reset) begin
      check("reset_byte_data", 64'(byte_data), 64'd0);
      check("reset_byte_last", 64'(byte_last), 64'd0);
      post_reset = 1'b0;
    end
    if (exp_valid) begin
      check("byte_data", 64'(byte_data), 64'(exp_q[0]));
      check("byte_last", 64'(byte_last), 64'(exp_q.size() == 1));
    end

    if (test_logic_reset) begin
      exp_q.delete();
      model_busy = 1'b0;
      post_reset = 1'b1;
    end else begin
      if (exp_valid && byte_ready) begin
        void'(exp_q.pop_front());
        pop_count++;
        if (exp_q.size() == 0) model_busy = 1'b0;
      end
      if (can_accept && value_valid) begin
        push_expected(value_data);
        model_busy = 1'b1;
        accept_cyc = cyc + 1;
        accept_count++;
      end
    end
  end

  // One clock; byte_ready is redrawn each cycle from the current duty.
  task automatic step();
    @(posedge tck);
    #1;
    byte_ready = ($urandom_range(99) < duty);
  endtask

  task automatic wait_accept(input int start_count);
    int n;
    n = 0;
    while (accept_count == start_count && n < 400) begin
      step();
      n++;
    end
    check("accept_timeout", 64'(accept_count != start_count), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (model_busy && n < 1000) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(model_busy), 64'd0);
  endtask

  task automatic run_value(input logic [63:0] v);
    int start_count;
    start_count = accept_count;
    value_valid = 1'b1;
    value_data  = v;
    wait_accept(start_count);
    value_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int start_count;
    int n;
    logic [63:0] rv;

    test_logic_reset = 1'b1;
    value_valid      = 1'b0;
    value_data       = '0;
    byte_ready       = 1'b1;
    repeat (3) step();
    test_logic_reset = 1'b0;
    step();

    // Directed values with the sink always ready.
    duty = 100;
    run_value(64'd0);
    run_value(64'd12345);
    run_value(64'hFFFF_FFFF_FFFF_FFFF);
    run_value(64'd10000000000000000000);

    // Backpressure on a short number.
    duty = 30;
    run_value(64'd907);

    // value_valid held high across two values: second one waits for the LF.
    duty = 100;
    start_count = accept_count;
    value_valid = 1'b1;
    value_data  = 64'd7;
    wait_accept(start_count);
    value_data  = 64'd42;
    wait_accept(start_count + 1);
    value_valid = 1'b0;
    wait_idle();

    // Reset during emission of 12345 after two bytes, then a clean value.
    start_count = accept_count;
    value_valid = 1'b1;
    value_data  = 64'd12345;
    wait_accept(start_count);
    value_valid = 1'b0;
    start_count = pop_count;
    n = 0;
    while (pop_count < start_count + 2 && n < 200) begin
      step();
      n++;
    end
    check("two_bytes_before_reset", 64'(pop_count - start_count), 64'd2);
    test_logic_reset = 1'b1;
    step();
    test_logic_reset = 1'b0;
    check("after_reset_byte_valid", 64'(byte_valid), 64'd0);
    check("after_reset_value_ready", 64'(value_ready), 64'd1);
    step();
    run_value(64'd5);

    // Random values of random magnitude under random backpressure.
    for (int i = 0; i < 12; i++) begin
      rv   = {$urandom, $urandom};
      rv   = rv >> $urandom_range(63);
      duty = $urandom_range(100, 25);
      run_value(rv);
    end

    duty = 100;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_result_ascii_encoder

// File: doc/result_ascii_encoder.md
# result_ascii_encoder

Converts a binary result, such as the 64-bit puzzle grand total, into an ASCII decimal byte stream terminated by a line feed. It is the output-side counterpart of the ASCII-to-binary input parsing. It sits between the result accumulator and a byte-wide TAP encoder, so the host reads a printable answer over JTAG. Internally it runs a sequential double-dabble conversion, then emits one byte per handshake.

## Interface
Parameters:
- VALUE_WIDTH, 64, width of the binary input value.
- DIGIT_COUNT, 20, number of BCD digits held. Must satisfy 10^DIGIT_COUNT > 2^VALUE_WIDTH − 1.
- BYTE_WIDTH, 8, output byte width.

Ports:
- tck  in  1  sole clock; all logic on posedge.
- test_logic_reset  in  1  reset, synchronous, active-high.
- value_valid  in  1  input value offered.
- value_data  in  VALUE_WIDTH  unsigned binary value.
- value_ready  out  1  block idle; a transfer occurs when value_valid && value_ready.
- byte_valid  out  1  byte_data holds a valid byte.
- byte_data  out  BYTE_WIDTH  ASCII character.
- byte_last  out  1  marks the terminating 0x0A byte.
- byte_ready  in  1  downstream accepts; a transfer occurs when byte_valid && byte_ready.

## Operation
- States: IDLE → CONVERT → SCAN → EMIT → NEWLINE → IDLE.
- IDLE:
  - value_ready = 1, byte_valid = 0.
  - On a value transfer: latch value_data into the shift register, clear the BCD register, load bit counter = VALUE_WIDTH, go to CONVERT.
- CONVERT: double dabble, one bit per cycle.
  - Each BCD digit ≥ 5 gets +3.
  - Then {bcd, shift} shifts left one bit.
  - After VALUE_WIDTH shifts, go to SCAN.
- SCAN: one cycle.
  - Digit pointer ← index of the most significant nonzero digit.
  - If all digits are zero, pointer ← 0, so value 0 emits "0".
  - Go to EMIT.
- EMIT:
  - byte_valid = 1, byte_data = 0x30 + digit[ptr], byte_last = 0.
  - On a byte transfer: if ptr == 0 go to NEWLINE, else ptr − 1.
- NEWLINE:
  - byte_valid = 1, byte_data = 0x0A, byte_last = 1.
  - On a byte transfer: go to IDLE.
- value_ready = (state == IDLE). value_valid is ignored in every other state; no queuing.
- Leading zeros are never emitted. Emitted digit count ranges from 1 to DIGIT_COUNT.
- Arithmetic: add-3 applies per 4-bit digit and has no carry between digits. The BCD register is 4·DIGIT_COUNT bits and never overflows, given the parameter constraint.

## Timing
- Reset (test_logic_reset high at a posedge), effective from any state including mid-CONVERT or mid-EMIT:
  - State goes to IDLE; byte_valid = 0, byte_last = 0, byte_data = 0x00.
  - value_ready reads 1 while reset is held, but value transfers during reset are discarded.
  - A partially emitted number is abandoned; no newline is sent.
- Latency:
  - The accepting edge is E0.
  - CONVERT occupies edges E1..E_VALUE_WIDTH.
  - SCAN occurs at E_VALUE_WIDTH+1.
  - byte_valid rises after E_VALUE_WIDTH+1, i.e. 65 edges for the defaults.
- Throughput: with byte_ready held high, one byte per cycle. The next value can be accepted on the cycle after the newline transfer.
- Backpressure:
  - While byte_valid && !byte_ready, byte_data and byte_last stay stable.
  - byte_valid never drops without a transfer, except on reset.
- byte_valid does not depend combinationally on byte_ready.
- Simultaneous events: a value_valid arriving in the same cycle as the newline transfer is not accepted, because value_ready is still 0 in that cycle.

## Structure
- Shared package holds BYTE_WIDTH and the ASCII constants ASCII_ZERO = 8'h30 and ASCII_LF = 8'h0A. These are the same constants the input parser uses.
- The state enum is local to the block.
- One sub-module is natural: bcd_double_dabble. It is parameterized by VALUE_WIDTH and DIGIT_COUNT, has a start/busy/done handshake, and exposes the BCD digit vector.
- The top level contains SCAN, the emit FSM and the pointer.

## Test plan
- Value 0 with byte_ready = 1 → bytes 0x30, 0x0A; byte_last only on 0x0A; byte_valid first high 65 edges after acceptance.
- Value 12345 → 0x31 0x32 0x33 0x34 0x35 0x0A, with no leading 0x30 bytes.
- Value 2^64−1 → the 20 digits "18446744073709551615" then 0x0A. Value 10^19 → "1" followed by 19 × 0x30.
- byte_ready pseudo-random, 30% duty, value 907 → byte_data and byte_last held while stalled; sequence 0x39 0x30 0x37 0x0A intact.
- value_valid held high continuously with values 7 then 42 → value_ready low throughout conversion and emission; 42 is accepted only after 7's 0x0A transfer; output "7\n42\n".
- Reset asserted mid-EMIT of 12345 after two bytes → next cycle byte_valid = 0 and value_ready = 1; a following value 5 emits "5\n" cleanly.
